seqgen_tx: RTL and testbench

Serial bit-pattern transmitter for the sequence-detector path. It latches a pattern word and a length on a start strobe, then shifts the pattern out MSB-first on `x`, one bit per clock. It can repeat the frame with programmable idle gaps. It is the stimulus end of the `x` serial line consumed by the sequence detector; for example, pattern `10010` drives the detector to its detect state.

---
 rtl/seqgen_tx.sv | 170 +++++++++++++++++
 tb/tb_seqgen_tx.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/seqgen_tx.sv
// Serial bit-pattern transmitter: shifts a latched pattern out MSB-first on x.
// Define SEQGEN_REPEAT_EN to build frame repetition with programmable idle gaps.
module seqgen_tx #(
    parameter int   WIDTH    = 8,
    parameter int   LENW     = 4,
    parameter logic IDLE_BIT = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] pattern,
    input  logic [LENW-1:0]  len,
    input  logic [3:0]       repeat_cnt,
    input  logic [3:0]       gap,
    output logic             ready,
    output logic             x,
    output logic             x_valid,
    output logic             done
);

    localparam int IDXW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT
`ifdef SEQGEN_REPEAT_EN
        , ST_GAP
`endif
    } state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  pattern_q, pattern_d;
    logic [IDXW-1:0]   idx_q, idx_d;
    logic              x_q, x_d;
    logic              x_valid_q, x_valid_d;
    logic              done_q, done_d;

    logic [LENW-1:0]   len_clamped;
    logic [IDXW-1:0]   start_idx;
    logic [IDXW-1:0]   idx_dec;

`ifdef SEQGEN_REPEAT_EN
    logic [IDXW-1:0]   len_m1_q, len_m1_d;
    logic [4:0]        frames_q, frames_d;
    logic [3:0]        gap_q, gap_d;
    logic [3:0]        gap_cnt_q, gap_cnt_d;
`else
    logic              unused_cfg;
    assign unused_cfg = ^{repeat_cnt, gap};
`endif

    assign len_clamped = (len > LENW'(WIDTH)) ? LENW'(WIDTH) : len;
    assign start_idx   = IDXW'(len_clamped - LENW'(1));
    assign idx_dec     = idx_q - IDXW'(1);

    // NOTE: every *_d gets a default before the case, so no path can infer a latch.
    always_comb begin
        state_d   = state_q;
        pattern_d = pattern_q;
        idx_d     = idx_q;
        x_d       = IDLE_BIT;
        x_valid_d = 1'b0;
        done_d    = 1'b0;
`ifdef SEQGEN_REPEAT_EN
        len_m1_d  = len_m1_q;
        frames_d  = frames_q;
        gap_d     = gap_q;
        gap_cnt_d = gap_cnt_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    pattern_d = pattern;
`ifdef SEQGEN_REPEAT_EN
                    len_m1_d  = start_idx;
                    frames_d  = 5'(repeat_cnt) + 5'd1;
                    gap_d     = gap;
`endif
                    if (len_clamped != '0) begin
                        state_d   = ST_SHIFT;
                        idx_d     = start_idx;
                        x_d       = pattern[start_idx];
                        x_valid_d = 1'b1;
                    end else begin
                        done_d    = 1'b1;
                    end
                end
            end
            ST_SHIFT: begin
                // idx_q names the bit on x this cycle; x_d presents the next one.
                if (idx_q != '0) begin
                    idx_d     = idx_dec;
                    x_d       = pattern_q[idx_dec];
                    x_valid_d = 1'b1;
                end else begin
`ifdef SEQGEN_REPEAT_EN
                    if (frames_q > 5'd1) begin
                        frames_d = frames_q - 5'd1;
                        if (gap_q != '0) begin
                            state_d   = ST_GAP;
                            gap_cnt_d = gap_q - 4'd1;
                        end else begin
                            idx_d     = len_m1_q;
                            x_d       = pattern_q[len_m1_q];
                            x_valid_d = 1'b1;
                        end
                    end else begin
                        state_d  = ST_IDLE;
                        frames_d = '0;
                        done_d   = 1'b1;
                    end
`else
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
`endif
                end
            end
`ifdef SEQGEN_REPEAT_EN
            ST_GAP: begin
                if (gap_cnt_q != '0) begin
                    gap_cnt_d = gap_cnt_q - 4'd1;
                end else begin
                    state_d   = ST_SHIFT;
                    idx_d     = len_m1_q;
                    x_d       = pattern_q[len_m1_q];
                    x_valid_d = 1'b1;
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            pattern_q <= '0;
            idx_q     <= '0;
            x_q       <= IDLE_BIT;
            x_valid_q <= 1'b0;
            done_q    <= 1'b0;
`ifdef SEQGEN_REPEAT_EN
            len_m1_q  <= '0;
            frames_q  <= '0;
            gap_q     <= '0;
            gap_cnt_q <= '0;
`endif
        end else begin
            state_q   <= state_d;
            pattern_q <= pattern_d;
            idx_q     <= idx_d;
            x_q       <= x_d;
            x_valid_q <= x_valid_d;
            done_q    <= done_d;
`ifdef SEQGEN_REPEAT_EN
            len_m1_q  <= len_m1_d;
            frames_q  <= frames_d;
            gap_q     <= gap_d;
            gap_cnt_q <= gap_cnt_d;
`endif
        end
    end

    assign ready   = (state_q == ST_IDLE);
    assign x       = x_q;
    assign x_valid = x_valid_q;
    assign done    = done_q;

endmodule

// File: tb/tb_seqgen_tx.sv
// Scoreboard bench for seqgen_tx: a per-cycle expected trace {ready,x_valid,x,done}
// is queued at each start and popped/compared on every falling edge.
module tb_seqgen_tx;

    localparam int   WIDTH = 8;
    localparam logic IDLE  = 1'b0;
`ifdef SEQGEN_REPEAT_EN
    localparam bit REPEAT_EN = 1'b1;
`else
    localparam bit REPEAT_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] pattern;
    logic [3:0] len;
    logic [3:0] repeat_cnt;
    logic [3:0] gap;
    logic       ready;
    logic       x;
    logic       x_valid;
    logic       done;

    int checks   = 0;
    int failures = 0;

    logic [3:0] exp_q[$];

    typedef struct {
        logic [7:0] p;
        logic [3:0] l;
        logic [3:0] r;
        logic [3:0] g;
    } vec_t;

    seqgen_tx #(.WIDTH(WIDTH), .LENW(4), .IDLE_BIT(IDLE)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .pattern    (pattern),
        .len        (len),
        .repeat_cnt (repeat_cnt),
        .gap        (gap),
        .ready      (ready),
        .x          (x),
        .x_valid    (x_valid),
        .done       (done)
    );

    always #5 clk = ~clk;

    // Expected trace of one start, beginning with the cycle after the start edge.
    function automatic void push_frame(input logic [7:0] pat, input int l_in,
                                       input int rep, input int g_in);
        int l;
        int f_tot;
        int gg;
        l     = (l_in > WIDTH) ? WIDTH : l_in;
        f_tot = REPEAT_EN ? rep + 1 : 1;
        gg    = REPEAT_EN ? g_in : 0;
        if (l == 0) begin
            exp_q.push_back({1'b1, 1'b0, IDLE, 1'b1});
            return;
        end
        for (int f = 0; f < f_tot; f++) begin
            for (int b = l - 1; b >= 0; b--)
                exp_q.push_back({1'b0, 1'b1, pat[b], 1'b0});
            if (f < f_tot - 1)
                for (int k = 0; k < gg; k++)
                    exp_q.push_back({1'b0, 1'b0, IDLE, 1'b0});
        end
        exp_q.push_back({1'b1, 1'b0, IDLE, 1'b1});
    endfunction

    // Drives one start pulse; afterwards scrambles inputs, which must not matter.
    task automatic launch(input logic [7:0] pat, input logic [3:0] l,
                          input logic [3:0] r, input logic [3:0] g);
        int n;
        n = 0;
        @(posedge clk); #1;
        while (ready !== 1'b1 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 100) begin
            checks++;
            failures++;
            $display("FAIL ready_wait got=%b want=1", ready);
        end
        pattern    = pat;
        len        = l;
        repeat_cnt = r;
        gap        = g;
        start      = 1'b1;
        push_frame(pat, int'(l), int'(r), int'(g));
        @(posedge clk); #1;
        start      = 1'b0;
        pattern    = ~pat;
        len        = 4'(l + 4'd3);
        repeat_cnt = ~r;
        gap        = ~g;
    endtask

    task automatic test_reset();
        logic [3:0] obs;
        rst = 1'b1; start = 1'b1; pattern = 8'hFF; len = 4'd5;
        repeat_cnt = 4'd0; gap = 4'd0;
        repeat (2) @(posedge clk);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            obs = {ready, x_valid, x, done};
            checks++;
            if (obs !== {1'b1, 1'b0, IDLE, 1'b0}) begin
                failures++;
                $display("FAIL reset_state cyc%0d got=%b want=%b", c, obs, {1'b1, 1'b0, IDLE, 1'b0});
            end
            if (c == 1) begin
                rst = 1'b0;
                start = 1'b0;
            end
        end
    endtask

    task automatic test_protocol();
        logic [3:0] obs;
        logic [3:0] e;
        int k;
        launch(8'hA5, 4'd8, 4'd0, 4'd0);
        k = 0;
        while (exp_q.size() > 0 && k < 100) begin
            @(negedge clk);
            k++;
            obs = {ready, x_valid, x, done};
            e = exp_q.pop_front();
            checks++;
            if (obs !== e) begin
                failures++;
                $display("FAIL protocol cyc%0d got=%b want=%b", k, obs, e);
            end
            // Reset lands at the end of cycle T+3: afterwards only idle, no done.
            if (k == 3) begin
                exp_q.delete();
                repeat (3) exp_q.push_back({1'b1, 1'b0, IDLE, 1'b0});
            end
            @(posedge clk); #1;
            if (k == 1) begin
                start = 1'b1;
                pattern = 8'hFF;
                len = 4'd3;
            end else if (k == 2) begin
                start = 1'b0;
                rst = 1'b1;
            end else if (k == 3) begin
                rst = 1'b0;
            end
        end
        if (exp_q.size() > 0) begin
            checks++;
            failures++;
            $display("FAIL protocol_timeout got=%0d want=0 pending", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_frames();
        vec_t vecs[7];
        logic [3:0] obs;
        logic [3:0] e;
        int n;
        vecs = '{
            '{8'h12, 4'd5,  4'd0,  4'd0},
            '{8'h12, 4'd5,  4'd2,  4'd0},
            '{8'h12, 4'd5,  4'd1,  4'd3},
            '{8'hA5, 4'd0,  4'd3,  4'd2},
            '{8'hC3, 4'd12, 4'd0,  4'd0},
            '{8'h5A, 4'd3,  4'd3,  4'd1},
            '{8'h81, 4'd8,  4'd15, 4'd0}
        };
        for (int v = 0; v < 7; v++) begin
            launch(vecs[v].p, vecs[v].l, vecs[v].r, vecs[v].g);
            n = 0;
            while (exp_q.size() > 0 && n < 400) begin
                @(negedge clk);
                n++;
                obs = {ready, x_valid, x, done};
                e = exp_q.pop_front();
                checks++;
                if (obs !== e) begin
                    failures++;
                    $display("FAIL frame%0d cyc%0d got=%b want=%b", v, n, obs, e);
                end
            end
            if (exp_q.size() > 0) begin
                checks++;
                failures++;
                $display("FAIL frame%0d_timeout got=%0d want=0 pending", v, exp_q.size());
                exp_q.delete();
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] obs;
        logic [3:0] e;
        int n;
        bit launched;
        launched = 1'b0;
        launch(8'h12, 4'd5, 4'd0, 4'd0);
        n = 0;
        while (exp_q.size() > 0 && n < 100) begin
            @(negedge clk);
            n++;
            obs = {ready, x_valid, x, done};
            e = exp_q.pop_front();
            checks++;
            if (obs !== e) begin
                failures++;
                $display("FAIL back_to_back cyc%0d got=%b want=%b", n, obs, e);
            end
            @(posedge clk); #1;
            if (launched && start) begin
                start = 1'b0;
                pattern = 8'h00;
            end
            // Only the done entry is left: the cycle now starting is the done cycle.
            if (!launched && exp_q.size() == 1) begin
                pattern    = 8'hB7;
                len        = 4'd4;
                repeat_cnt = 4'd0;
                gap        = 4'd0;
                start      = 1'b1;
                push_frame(8'hB7, 4, 0, 0);
                launched   = 1'b1;
            end
        end
        if (exp_q.size() > 0) begin
            checks++;
            failures++;
            $display("FAIL back_to_back_timeout got=%0d want=0 pending", exp_q.size());
            exp_q.delete();
        end
    endtask

    initial begin
        test_reset();
        test_protocol();
        test_frames();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL global_timeout got=running want=finished");
        $fatal(1, "time limit exceeded");
    end

endmodule
